ram_port_arbiter: RTL and testbench
===================================

// Module: ram_port_arbiter
// PURPOSE
//  Parametrised byte-serial RAM controller, successor to the single-fetch/single-data controller.
//  Arbitrates an instruction-fetch channel (FETCH_BYTES-byte bursts, line fill) and a data channel (1/2/4-byte LD/ST).
//  Serialises each request onto the 8-bit synchronous RAM port.
//  Sits between icache/LSB and the top-level RAM/IO bus; honours rdy, io_buffer_full and branch-mispredict flush.
// PARAMETERS
//  ADDR_W       32  address width of all address ports
//  FETCH_BYTES  4   bytes per instruction fetch burst; power of two, 4..64; inst_data is FETCH_BYTES*8 wide
//  CNT_W        $clog2(FETCH_BYTES)+1  byte-counter width (derived, do not override)
// PORTS
//  clk            in   1              system clock
//  rst            in   1              asynchronous reset, active-low
//  rdy            in   1              global enable; 0 = freeze all state
//  flush          in   1              mispredict; aborts in-flight fetch only
//  inst_req       in   1              fetch request, level, held until inst_done
//  inst_addr      in   ADDR_W         fetch base address, FETCH_BYTES-aligned
//  inst_done      out  1              one-cycle pulse, inst_data valid
//  inst_data      out  FETCH_BYTES*8  fetched bytes, little-endian
//  mem_req        in   1              data request, level, held until mem_done
//  mem_wr         in   1              1 = store, 0 = load
//  mem_size       in   2              0 = byte, 1 = half, 2 = word, 3 = word
//  mem_signed     in   1              load sign-extend select (see CONFIGURATION)
//  mem_addr       in   ADDR_W         data byte address
//  mem_wdata      in   32             store data, low bytes used
//  mem_done       out  1              one-cycle pulse; load data valid / store committed
//  mem_rdata      out  32             load result
//  ram_in         in   8              RAM read byte; valid one cycle after its address
//  io_buffer_full in   1              IO write buffer full; stalls stores
//  ram_out        out  8              RAM write byte
//  ram_addr       out  ADDR_W         RAM byte address
//  ram_wr         out  1              1 = write, 0 = read
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, counter=0; inst_done=mem_done=0; inst_data=mem_rdata=0;
//   ram_wr=0, ram_addr=0, ram_out=0.
//  rdy=0: state, counter and outputs hold; ram_wr forced 0; no pulses issued.
//  FSM states: IDLE, LOAD, STORE, FETCH.
//   IDLE -> STORE if mem_req&mem_wr; LOAD if mem_req&!mem_wr; else FETCH if inst_req.
//   Data wins over fetch when both are requested; an accepted fetch is never pre-empted.
//  N = bytes of the request (1/2/4, or FETCH_BYTES).
//  Read (LOAD/FETCH): byte k addressed in cycle k, captured in cycle k+1.
//   done pulse registered in cycle N+1 after acceptance, returning to IDLE the same edge.
//   Minimum N+2 cycles request-to-request.
//  STORE: byte k driven with ram_wr=1 at base+k when io_buffer_full=0.
//   While io_buffer_full=1: ram_wr=0, ram_addr=0, counter holds.
//   mem_done pulses on the edge after the last byte is written.
//  ram_wr is 0 in every non-STORE cycle; ram_addr = base+counter, wrapping modulo 2^ADDR_W.
//  flush: in FETCH or IDLE-with-inst_req, next edge -> IDLE, counter=0, no inst_done.
//   Ignored in LOAD/STORE; a simultaneous mem_req is still accepted.
//  Requester must deassert req in the cycle after done, or present a new request (accepted then).
//  Unaligned data addresses are serviced byte-wise, with no fault.
// CONFIGURATION
//  RAM_PORT_SIGN_EXT_EN defined:
//   loads with mem_signed=1 sign-extend the top fetched byte/half to 32 bits; mem_signed=0 zero-extends.
//  RAM_PORT_SIGN_EXT_EN undefined:
//   mem_signed is ignored; all loads zero-extend and the LSB performs extension.
// STRUCTURE
//  Shared defines header: state encodings, size encodings (SIZE_B/H/W), RstEnable-low constant, ZeroWord.
//  Sub-module ram_load_align: byte shift-register capture plus size/extension mux.
//   Combinational output, registered by the parent.
// TESTING
//  1 Fetch, FETCH_BYTES=16, addr 0x100, RAM = incrementing bytes -> inst_done at cycle 17, data 0x0F0E..0100.
//  2 Word load 0x200 = {0x80,0x12,0x34,0x56} high->low, signed, macro on -> mem_rdata 0x80123456;
//    half load -> 0x00003456 (sign bit clear); byte load at 0x203 -> 0xFFFFFF80 (on) / 0x00000080 (off).
//  3 Word store 0xDEADBEEF to 0x30000 with io_buffer_full high cycles 1-3 -> 4 ram_wr pulses, EF,BE,AD,DE.
//    mem_done is delayed exactly 3 cycles.
//  4 inst_req and mem_req raised in the same cycle -> data served first; fetch starts the cycle after mem_done.
//  5 flush in cycle 2 of a fetch -> no inst_done, IDLE next cycle; a later fetch returns correct data.
//  6 rst low mid-store, and rdy low for 5 cycles mid-load -> reset values immediately / load completes 5 cycles late with correct data.

Source files
------------

// File: rtl/ram_port_arbiter_pkg.sv
// rtl/ram_port_arbiter_pkg.sv - shared state/size encodings and constants for the RAM port arbiter
package ram_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_STORE = 2'd2,
      ST_FETCH = 2'd3
   } state_t;

   localparam logic [1:0]  SIZE_B     = 2'd0;
   localparam logic [1:0]  SIZE_H     = 2'd1;
   localparam logic [1:0]  SIZE_W     = 2'd2;
   localparam logic        RST_ENABLE = 1'b0;
   localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;

   function automatic logic [2:0] size_bytes(input logic [1:0] size);
      case (size)
         SIZE_B:  size_bytes = 3'd1;
         SIZE_H:  size_bytes = 3'd2;
         default: size_bytes = 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/ram_port_arbiter_load_align.sv
// rtl/ram_port_arbiter_load_align.sv - byte capture shift register plus load size/extension mux
// Optional RAM_PORT_SIGN_EXT_EN enables sign extension of byte/half loads.
module ram_port_arbiter_load_align
   import ram_port_arbiter_pkg::*;
#(
   parameter int FW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          capture,
   input  logic [7:0]    ram_in,
   input  logic [1:0]    size,
   input  logic          sign_en,
   output logic [FW-1:0] shifted,
   output logic [31:0]   load_word
);

   logic [FW-1:0] buffer;
   logic          fill;

   // Newest byte enters at the top, so the last N bytes of a burst sit little-endian in the top N bytes.
   assign shifted = {ram_in, buffer[FW-1:8]};

   always_ff @(posedge clk or negedge rst) begin
      if (rst == RST_ENABLE)
         buffer <= '0;
      else if (capture)
         buffer <= shifted;
   end

`ifdef RAM_PORT_SIGN_EXT_EN
   assign fill = sign_en & shifted[FW-1];
`else
   logic unused_sign_en;
   assign unused_sign_en = sign_en;
   assign fill = 1'b0;
`endif

   always_comb begin
      load_word = ZERO_WORD;
      case (size)
         SIZE_B:  load_word = {{24{fill}}, shifted[FW-1 -: 8]};
         SIZE_H:  load_word = {{16{fill}}, shifted[FW-1 -: 16]};
         default: load_word = shifted[FW-1 -: 32];
      endcase
   end

endmodule

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - arbitrates fetch bursts and data LD/ST onto a byte-serial RAM port
// Optional RAM_PORT_SIGN_EXT_EN enables sign-extending loads.
module ram_port_arbiter
   import ram_port_arbiter_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int FETCH_BYTES = 4,
   parameter int CNT_W       = $clog2(FETCH_BYTES) + 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rdy,
   input  logic                     flush,
   input  logic                     inst_req,
   input  logic [ADDR_W-1:0]        inst_addr,
   output logic                     inst_done,
   output logic [FETCH_BYTES*8-1:0] inst_data,
   input  logic                     mem_req,
   input  logic                     mem_wr,
   input  logic [1:0]               mem_size,
   input  logic                     mem_signed,
   input  logic [ADDR_W-1:0]        mem_addr,
   input  logic [31:0]              mem_wdata,
   output logic                     mem_done,
   output logic [31:0]              mem_rdata,
   input  logic [7:0]               ram_in,
   input  logic                     io_buffer_full,
   output logic [7:0]               ram_out,
   output logic [ADDR_W-1:0]        ram_addr,
   output logic                     ram_wr
);

   localparam int FW = FETCH_BYTES * 8;

   state_t            state, state_nx;
   logic [CNT_W-1:0]  cnt, cnt_nx, n_bytes;
   logic [ADDR_W-1:0] base, base_nx;
   logic [1:0]        size_q, size_nx;
   logic [31:0]       wdata_q, wdata_nx;
   logic              sign_q, sign_nx;
   logic              inst_done_nx, mem_done_nx, capture, idle_ok;
   logic [FW-1:0]     shifted;
   logic [31:0]       load_word;

   // The done cycle still sees the finished request held high, so acceptance waits one cycle.
   assign idle_ok = rdy && (rst != RST_ENABLE) && !inst_done && !mem_done;
   assign n_bytes = (state == ST_FETCH) ? CNT_W'(FETCH_BYTES) : CNT_W'(size_bytes(size_q));

   always_comb begin
      state_nx     = state;
      cnt_nx       = cnt;
      base_nx      = base;
      size_nx      = size_q;
      wdata_nx     = wdata_q;
      sign_nx      = sign_q;
      inst_done_nx = 1'b0;
      mem_done_nx  = 1'b0;
      capture      = 1'b0;
      ram_wr       = 1'b0;
      ram_addr     = '0;
      ram_out      = 8'h00;
      case (state)
         ST_IDLE: begin
            if (idle_ok && mem_req) begin
               base_nx  = mem_addr;
               size_nx  = mem_size;
               wdata_nx = mem_wdata;
               sign_nx  = mem_signed;
               if (mem_wr) begin
                  state_nx = ST_STORE;
                  cnt_nx   = '0;
               end else begin
                  state_nx = ST_LOAD;
                  cnt_nx   = CNT_W'(1);
                  ram_addr = mem_addr;
               end
            end else if (idle_ok && inst_req && !flush) begin
               state_nx = ST_FETCH;
               base_nx  = inst_addr;
               cnt_nx   = CNT_W'(1);
               ram_addr = inst_addr;
            end
         end
         ST_LOAD, ST_FETCH: begin
            // While frozen, re-address the byte due next so ram_in is still valid on resume.
            ram_addr = base + ADDR_W'(cnt) - ADDR_W'(!rdy);
            if (rdy) begin
               capture = 1'b1;
               if (state == ST_FETCH && flush) begin
                  state_nx = ST_IDLE;
                  cnt_nx   = '0;
               end else if (cnt == n_bytes) begin
                  state_nx     = ST_IDLE;
                  cnt_nx       = '0;
                  inst_done_nx = (state == ST_FETCH);
                  mem_done_nx  = (state == ST_LOAD);
               end else begin
                  cnt_nx = cnt + CNT_W'(1);
               end
            end
         end
         ST_STORE: begin
            if (!io_buffer_full) begin
               ram_addr = base + ADDR_W'(cnt);
               ram_out  = wdata_q[{cnt[1:0], 3'b000} +: 8];
               if (rdy) begin
                  ram_wr = 1'b1;
                  if (cnt == n_bytes - CNT_W'(1)) begin
                     state_nx    = ST_IDLE;
                     cnt_nx      = '0;
                     mem_done_nx = 1'b1;
                  end else begin
                     cnt_nx = cnt + CNT_W'(1);
                  end
               end
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (rst == RST_ENABLE) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         base      <= '0;
         size_q    <= SIZE_B;
         wdata_q   <= ZERO_WORD;
         sign_q    <= 1'b0;
         inst_done <= 1'b0;
         mem_done  <= 1'b0;
         inst_data <= '0;
         mem_rdata <= ZERO_WORD;
      end else if (rdy) begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         base      <= base_nx;
         size_q    <= size_nx;
         wdata_q   <= wdata_nx;
         sign_q    <= sign_nx;
         inst_done <= inst_done_nx;
         mem_done  <= mem_done_nx;
         if (inst_done_nx)
            inst_data <= shifted;
         if (mem_done_nx && state == ST_LOAD)
            mem_rdata <= load_word;
      end else begin
         inst_done <= 1'b0;
         mem_done  <= 1'b0;
      end
   end

   ram_port_arbiter_load_align #(.FW(FW)) u_align (
      .clk       (clk),
      .rst       (rst),
      .capture   (capture),
      .ram_in    (ram_in),
      .size      (size_q),
      .sign_en   (sign_q),
      .shifted   (shifted),
      .load_word (load_word)
   );

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - directed self-checking bench for ram_port_arbiter (FETCH_BYTES=16)
module tb_ram_port_arbiter;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         rdy = 1'b1;
   logic         flush = 1'b0;
   logic         inst_req = 1'b0;
   logic [31:0]  inst_addr = '0;
   logic         inst_done;
   logic [127:0] inst_data;
   logic         mem_req = 1'b0;
   logic         mem_wr = 1'b0;
   logic [1:0]   mem_size = 2'd0;
   logic         mem_signed = 1'b0;
   logic [31:0]  mem_addr = '0;
   logic [31:0]  mem_wdata = '0;
   logic         mem_done;
   logic [31:0]  mem_rdata;
   logic [7:0]   ram_in = 8'h00;
   logic [7:0]   ram_next = 8'h00;
   logic         io_buffer_full = 1'b0;
   logic [7:0]   ram_out;
   logic [31:0]  ram_addr;
   logic         ram_wr;

   logic [7:0]   mem [0:4095];
   logic [31:0]  log_addr [$];
   logic [7:0]   log_data [$];
   int           total = 0;
   int           bad = 0;

   ram_port_arbiter #(.ADDR_W(32), .FETCH_BYTES(16)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_done(inst_done), .inst_data(inst_data),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_signed(mem_signed),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
      .ram_in(ram_in), .io_buffer_full(io_buffer_full), .ram_out(ram_out),
      .ram_addr(ram_addr), .ram_wr(ram_wr)
   );

   always #5 clk = ~clk;

   // Synchronous RAM: address seen mid-cycle, byte returned the next cycle.
   always @(negedge clk) begin
      ram_next = mem[ram_addr[11:0]];
      if (ram_wr) begin
         log_addr.push_back(ram_addr);
         log_data.push_back(ram_out);
      end
   end
   always @(posedge clk) ram_in <= ram_next;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_done(input bit want_inst, output int cyc);
      cyc = 0;
      while (cyc < 60) begin
         step();
         cyc++;
         if ((want_inst ? inst_done : mem_done) === 1'b1) return;
      end
      cyc = -1;
   endtask

   task automatic start_load(input logic [31:0] addr, input logic [1:0] size, input logic sgn);
      mem_req = 1'b1; mem_wr = 1'b0; mem_addr = addr; mem_size = size; mem_signed = sgn;
   endtask

   initial begin
      int c, mc, ic, pulses;
      logic [31:0] exp_b;
      for (int i = 0; i < 4096; i++) mem[i] = i[7:0];
      mem[12'h200] = 8'h56; mem[12'h201] = 8'h34; mem[12'h202] = 8'h12; mem[12'h203] = 8'h80;

      // reset state
      #2;
      check("rst_inst_done", inst_done, 0);
      check("rst_mem_done", mem_done, 0);
      check("rst_inst_data", inst_data, 0);
      check("rst_mem_rdata", mem_rdata, 0);
      check("rst_ram_wr", ram_wr, 0);
      check("rst_ram_addr", ram_addr, 0);
      check("rst_ram_out", ram_out, 0);
      step(); step();
      rst = 1'b1;
      step();

      // 1: 16-byte fetch
      inst_req = 1'b1; inst_addr = 32'h100;
      wait_done(1'b1, c);
      inst_req = 1'b0;
      check("fetch_latency", c, 17);
      check("fetch_data", inst_data, 128'h0F0E0D0C0B0A09080706050403020100);
      step();
      check("fetch_pulse_width", inst_done, 0);

      // 2: loads of various sizes
      start_load(32'h200, 2'd2, 1'b1);
      wait_done(1'b0, c);
      mem_req = 1'b0;
      check("word_latency", c, 5);
      check("word_data", mem_rdata, 32'h80123456);
      step();
      start_load(32'h200, 2'd1, 1'b1);
      wait_done(1'b0, c);
      mem_req = 1'b0;
      check("half_latency", c, 3);
      check("half_data", mem_rdata, 32'h00003456);
      step();
      start_load(32'h203, 2'd0, 1'b1);
      wait_done(1'b0, c);
      mem_req = 1'b0;
`ifdef RAM_PORT_SIGN_EXT_EN
      exp_b = 32'hFFFFFF80;
`else
      exp_b = 32'h00000080;
`endif
      check("byte_latency", c, 2);
      check("byte_data", mem_rdata, exp_b);
      step();

      // 3: word store with io_buffer_full high in cycles 1-3
      log_addr.delete(); log_data.delete();
      mem_req = 1'b1; mem_wr = 1'b1; mem_size = 2'd2; mem_addr = 32'h30000; mem_wdata = 32'hDEADBEEF;
      c = 0;
      while (c < 40) begin
         step();
         c++;
         if (mem_done === 1'b1) break;
         io_buffer_full = (c <= 3);
         if (c == 2) begin
            #1;
            check("stall_ram_wr", ram_wr, 0);
            check("stall_ram_addr", ram_addr, 0);
         end
      end
      mem_req = 1'b0; mem_wr = 1'b0; io_buffer_full = 1'b0;
      check("store_latency", c, 8);
      check("store_count", log_addr.size(), 4);
      if (log_addr.size() == 4) begin
         check("store_b0", {log_addr[0], log_data[0]}, {32'h30000, 8'hEF});
         check("store_b1", {log_addr[1], log_data[1]}, {32'h30001, 8'hBE});
         check("store_b2", {log_addr[2], log_data[2]}, {32'h30002, 8'hAD});
         check("store_b3", {log_addr[3], log_data[3]}, {32'h30003, 8'hDE});
      end
      step();

      // 4: simultaneous fetch and data request
      start_load(32'h200, 2'd2, 1'b0);
      inst_req = 1'b1; inst_addr = 32'h100;
      c = 0; mc = -1; ic = -1;
      while (c < 60) begin
         step();
         c++;
         if (mem_done === 1'b1) begin mc = c; mem_req = 1'b0; end
         if (inst_done === 1'b1) begin ic = c; break; end
      end
      inst_req = 1'b0;
      check("arb_mem_first", mc, 5);
      check("arb_load_data", mem_rdata, 32'h80123456);
      check("arb_fetch_after", ic, 23);
      check("arb_fetch_data", inst_data, 128'h0F0E0D0C0B0A09080706050403020100);
      step();

      // 5: flush in cycle 2 of a fetch
      inst_req = 1'b1; inst_addr = 32'h100;
      step(); step();
      flush = 1'b1;
      step();
      flush = 1'b0; inst_req = 1'b0;
      #1;
      check("flush_idle_addr", ram_addr, 0);
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         if (inst_done === 1'b1) pulses++;
         step();
      end
      check("flush_no_done", pulses, 0);
      inst_req = 1'b1; inst_addr = 32'h110;
      wait_done(1'b1, c);
      inst_req = 1'b0;
      check("refetch_latency", c, 17);
      check("refetch_data", inst_data, 128'h1F1E1D1C1B1A19181716151413121110);
      step();

      // 6a: reset in the middle of a store
      mem_req = 1'b1; mem_wr = 1'b1; mem_size = 2'd2; mem_addr = 32'h30000; mem_wdata = 32'h11223344;
      step(); step();
      rst = 1'b0;
      #1;
      check("midrst_ram_wr", ram_wr, 0);
      check("midrst_ram_addr", ram_addr, 0);
      check("midrst_ram_out", ram_out, 0);
      check("midrst_mem_rdata", mem_rdata, 0);
      check("midrst_inst_data", inst_data, 0);
      mem_req = 1'b0; mem_wr = 1'b0;
      step(); step();
      rst = 1'b1;
      step();

      // 6b: rdy low for 5 cycles in the middle of a load
      start_load(32'h200, 2'd2, 1'b0);
      c = 0;
      while (c < 60) begin
         step();
         c++;
         if (mem_done === 1'b1) break;
         rdy = !(c >= 2 && c <= 6);
      end
      mem_req = 1'b0; rdy = 1'b1;
      check("freeze_latency", c, 10);
      check("freeze_data", mem_rdata, 32'h80123456);
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
